// File: rtl/video_clken_gen.sv
// Per-channel phase-accumulator clock-enable generator with a settle/lock FSM.
// Optional macro VIDEO_CLKEN_PHASE_ALIGN_EN: accepted writes also clear every accumulator and toggle.
module video_clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int CH_W        = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = {32'd2834678415, 32'd2147483648, 32'd2147483648}
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t            state, state_next;
  logic [15:0]       cnt, cnt_next;
  logic              wr_ok;
  logic              run_en;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W-1:0]  sum [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] pulse;

  assign wr_ok = cfg_wr && (32'(cfg_ch) < 32'(NUM_CH));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A write always wins over the terminal count, so it restarts settling.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      UNLOCKED: begin
        if (wr_ok) begin
          cnt_next = '0;
        end else if (cnt == 16'(LOCK_CYCLES - 1)) begin
          state_next = LOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      LOCKED: begin
        if (wr_ok) begin
          state_next = UNLOCKED;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = UNLOCKED;
        cnt_next   = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

  always_comb begin
    carry = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      {carry[ch], sum[ch]} = {1'b0, acc[ch]} + {1'b0, inc[ch]};
    end
  end

  // Pulses pass only while locked before and after the edge: no pulse on the lock transition.
  assign run_en = (state == LOCKED) && (state_next == LOCKED);
  assign pulse  = carry & {NUM_CH{run_en}};

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= '0;
        inc[ch] <= DEFAULT_INC[ch*ACC_W +: ACC_W];
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef VIDEO_CLKEN_PHASE_ALIGN_EN
        if (wr_ok) begin
          acc[ch] <= '0;
        end else begin
          acc[ch] <= sum[ch];
        end
`else
        acc[ch] <= sum[ch];
`endif
        if (wr_ok && (cfg_ch == CH_W'(ch))) begin
          inc[ch] <= cfg_inc;
        end
      end
    end
  end

  // Toggles are cleared whenever unlocked, which also covers the phase-align clear.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      clken  <= '0;
      outclk <= '0;
    end else begin
      clken <= pulse;
      if (!run_en) begin
        outclk <= '0;
      end else begin
        outclk <= outclk ^ pulse;
      end
    end
  end

endmodule

// File: tb/tb_video_clken_gen.sv
// Directed self-checking bench for video_clken_gen (NUM_CH=3, LOCK_CYCLES=16).
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_video_clken_gen;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [2:0]  clken;
  logic [2:0]  outclk;
  logic        locked;

  int checks = 0;
  int passed = 0;

  video_clken_gen #(
    .NUM_CH(3), .ACC_W(32), .CH_W(2), .LOCK_CYCLES(16)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .clken(clken), .outclk(outclk), .locked(locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    cfg_wr = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic write_inc(input logic [1:0] ch, input logic [31:0] value);
    cfg_wr  = 1'b1;
    cfg_ch  = ch;
    cfg_inc = value;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_lock(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (locked === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    cfg_wr  = 1'b0;
    cfg_ch  = '0;
    cfg_inc = '0;
    repeat (2) @(negedge refclk);
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL reset_locked: got %b want 0", locked); else passed++;
    checks++;
    if (clken !== 3'b000) $display("[TB] FAIL reset_clken: got %b want 000", clken); else passed++;
    checks++;
    if (outclk !== 3'b000) $display("[TB] FAIL reset_outclk: got %b want 000", outclk); else passed++;
    rst_n = 1'b1;
    repeat (15) step();
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL lock_early: got %b want 0 after 15 edges", locked); else passed++;
    step();
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL lock_on_time: got %b want 1 after 16 edges", locked); else passed++;
    checks++;
    if (clken !== 3'b000) $display("[TB] FAIL lock_no_extra_pulse: got %b want 000", clken); else passed++;
  endtask

  // Continues from the lock edge (edge 16); ch0/ch1 carry on every even edge.
  task automatic test_default_rates();
    int cnt2;
    logic [1:0] exp;
    for (int e = 17; e <= 24; e++) begin
      step();
      exp = (e % 2 == 0) ? 2'b11 : 2'b00;
      checks++;
      if (clken[1:0] !== exp) $display("[TB] FAIL ch01_pattern edge %0d: got %b want %b", e, clken[1:0], exp); else passed++;
      if (e == 22) begin
        checks++;
        if (outclk[1:0] !== 2'b11) $display("[TB] FAIL ch01_outclk: got %b want 11", outclk[1:0]); else passed++;
      end
    end
    cnt2 = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (clken[2] === 1'b1) cnt2++;
    end
    checks++;
    if (cnt2 < 32 || cnt2 > 34) $display("[TB] FAIL ch2_rate: got %0d pulses want 33+/-1", cnt2); else passed++;
  endtask

  task automatic test_write_locked();
    int pulses, high, last, gap_bad;
    write_inc(2'd0, 32'd1073741824);
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL relock_drop: got %b want 0", locked); else passed++;
    repeat (15) step();
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL relock_early: got %b want 0", locked); else passed++;
    step();
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL relock_on_time: got %b want 1", locked); else passed++;
    pulses = 0; high = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (clken[0] === 1'b1) begin
        if (last >= 0 && (i - last) != 4) gap_bad++;
        last = i;
        pulses++;
      end
      if (outclk[0] === 1'b1) high++;
    end
    checks++;
    if (pulses != 4) $display("[TB] FAIL ch0_quarter_count: got %0d want 4", pulses); else passed++;
    checks++;
    if (gap_bad != 0) $display("[TB] FAIL ch0_quarter_spacing: got %0d bad gaps want 0", gap_bad); else passed++;
    checks++;
    if (high != 8) $display("[TB] FAIL ch0_outclk_duty: got %0d high cycles want 8", high); else passed++;
  endtask

  // ch1 is frozen at 2^31 by inc=0, so an all-ones increment never hits zero in 1000 cycles.
  task automatic test_extremes();
    bit ok;
    int cnt;
    do_reset();
    write_inc(2'd1, 32'd0);
    wait_lock(40, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL zero_inc_lock: got %b want 1", ok); else passed++;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (clken[1] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) $display("[TB] FAIL zero_inc_pulses: got %0d want 0", cnt); else passed++;
    write_inc(2'd1, 32'hFFFF_FFFF);
    wait_lock(40, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL max_inc_lock: got %b want 1", ok); else passed++;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (clken[1] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 1000) $display("[TB] FAIL max_inc_pulses: got %0d want 1000", cnt); else passed++;
  endtask

  task automatic test_bad_channel();
    int c0, c1, c2, dropped;
    write_inc(2'd3, 32'd0);
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL bad_ch_locked: got %b want 1", locked); else passed++;
    c0 = 0; c1 = 0; c2 = 0; dropped = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (locked !== 1'b1) dropped++;
      if (clken[0] === 1'b1) c0++;
      if (clken[1] === 1'b1) c1++;
    end
    for (int i = 0; i < 50; i++) begin
      step();
      if (clken[2] === 1'b1) c2++;
    end
    checks++;
    if (dropped != 0) $display("[TB] FAIL bad_ch_lock_drop: got %0d unlocked cycles want 0", dropped); else passed++;
    checks++;
    if (c0 != 10) $display("[TB] FAIL bad_ch_ch0: got %0d want 10", c0); else passed++;
    checks++;
    if (c1 != 20) $display("[TB] FAIL bad_ch_ch1: got %0d want 20", c1); else passed++;
    checks++;
    if (c2 < 32 || c2 > 34) $display("[TB] FAIL bad_ch_ch2: got %0d want 33+/-1", c2); else passed++;
  endtask

  task automatic test_terminal_write();
    do_reset();
    repeat (15) step();
    write_inc(2'd0, 32'h8000_0000);
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL terminal_write_wins: got %b want 0", locked); else passed++;
    repeat (15) step();
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL terminal_relock_early: got %b want 0", locked); else passed++;
    step();
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL terminal_relock: got %b want 1", locked); else passed++;
  endtask

  task automatic test_async_reset();
    bit ok;
    int c1;
    write_inc(2'd1, 32'd0);
    wait_lock(40, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL async_prelock: got %b want 1", ok); else passed++;
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0) $display("[TB] FAIL async_locked: got %b want 0", locked); else passed++;
    checks++;
    if (clken !== 3'b000 || outclk !== 3'b000)
      $display("[TB] FAIL async_outputs: got clken %b outclk %b want 000 000", clken, outclk);
    else passed++;
    do_reset();
    repeat (16) step();
    c1 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clken[1] === 1'b1) c1++;
    end
    checks++;
    if (c1 != 10) $display("[TB] FAIL async_inc_restored: got %0d want 10", c1); else passed++;
  endtask

  // Write at edge 1; ch0 phase relative to it shows whether accumulators were cleared.
  task automatic test_phase_align();
    logic [1:0] exp;
    bit odd_phase;
`ifdef VIDEO_CLKEN_PHASE_ALIGN_EN
    odd_phase = 1'b1;
`else
    odd_phase = 1'b0;
`endif
    do_reset();
    write_inc(2'd2, 32'd2834678415);
    repeat (16) step();
    checks++;
    if (locked !== 1'b1) $display("[TB] FAIL align_lock: got %b want 1", locked); else passed++;
    for (int e = 18; e <= 25; e++) begin
      step();
      exp = (((e % 2) == 1) == odd_phase) ? 2'b11 : 2'b00;
      checks++;
      if (clken[1:0] !== exp) $display("[TB] FAIL align_phase edge %0d: got %b want %b", e, clken[1:0], exp); else passed++;
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_default_rates();
    test_write_locked();
    test_extremes();
    test_bad_channel();
    test_terminal_write();
    test_async_reset();
    test_phase_align();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
